// File: rtl/nios_core_nios2_cpu_mul_combine.sv
// Multiplier combine stage: folds the three registered 16x16 partial products into the
// 32-bit MUL result, and for MULX ops builds the missing hi*hi product by shift-and-add
// before applying the signed-operand corrections to the upper word.
module nios_core_nios2_cpu_mul_combine #(
    // Multiplier bits of hi*hi retired per ITER cycle; legal values are 1, 2 and 4.
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [31:0] mul_cell_p1,
    input  logic [31:0] mul_cell_p2,
    input  logic [31:0] mul_cell_p3,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam logic [1:0] OpMul    = 2'd0;
    localparam logic [1:0] OpMulxsu = 2'd2;
    localparam logic [1:0] OpMulxss = 2'd3;

    typedef enum logic [1:0] {StIdle, StWaitP, StIter, StFinal} state_e;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] p1_q;
    logic [31:0] p2_q;
    logic [31:0] p3_q;
    logic [31:0] acc_q;
    logic [4:0]  count_q;

    logic        issue;
    logic [15:0] mid_lo;
    logic [31:0] mul_lo;
    logic [15:0] b_hi_sh;
    logic [31:0] a_hi_ext;
    logic [31:0] acc_d;
    logic [4:0]  count_d;
    logic [32:0] mid_sum;
    logic [63:0] full;
    logic [31:0] full_hi;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] hi_final;
    logic        unused_full_lo;

    // Ready in IDLE, and in WAIT_P only while it holds a MUL so MULs can stream every cycle.
    always_comb begin
        in_ready = (state_q == StIdle) || ((state_q == StWaitP) && (op_q == OpMul));
        busy     = ~in_ready;
        issue    = in_valid & in_ready;
    end

    // Low result word straight from the cell; only the low 16 bits of p2+p3 reach it.
    always_comb begin
        mid_lo = mul_cell_p2[15:0] + mul_cell_p3[15:0];
        mul_lo = mul_cell_p1 + {mid_lo, 16'h0000};
    end

    // Shift-and-add step for hi*hi: B's high half is pre-shifted so bit k is the current bit.
    always_comb begin
        a_hi_ext = {16'h0000, a_q[31:16]};
        b_hi_sh  = b_q[31:16] >> count_q;
        acc_d    = acc_q;
        for (int k = 0; k < int'(ITER_PER_CYCLE); k++) begin
            if (b_hi_sh[k]) begin
                acc_d = acc_d + (a_hi_ext << (32'(count_q) + k));
            end
        end
        count_d = count_q + 5'(ITER_PER_CYCLE);
    end

    // Full 64-bit unsigned product, then subtract the terms a signed operand would remove.
    always_comb begin
        mid_sum        = {1'b0, p2_q} + {1'b0, p3_q};
        full           = {32'h0, p1_q} + {15'h0, mid_sum, 16'h0000} + {acc_q, 32'h0};
        full_hi        = full[63:32];
        unused_full_lo = ^full[31:0];
        corr_a         = a_q[31] ? b_q : 32'h0;
        corr_b         = b_q[31] ? a_q : 32'h0;
        case (op_q)
            OpMulxsu: hi_final = full_hi - corr_a;
            OpMulxss: hi_final = full_hi - corr_a - corr_b;
            default:  hi_final = full_hi;
        endcase
    end

    // Control FSM with registered result strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= 2'd0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            p1_q       <= 32'h0;
            p2_q       <= 32'h0;
            p3_q       <= 32'h0;
            acc_q      <= 32'h0;
            count_q    <= 5'd0;
            out_valid  <= 1'b0;
            out_result <= 32'h0;
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        op_q    <= in_op;
                        a_q     <= in_src1;
                        b_q     <= in_src2;
                        state_q <= StWaitP;
                    end
                end
                StWaitP: begin
                    if (op_q == OpMul) begin
                        out_valid  <= 1'b1;
                        out_result <= mul_lo;
                        if (issue) begin
                            op_q    <= in_op;
                            a_q     <= in_src1;
                            b_q     <= in_src2;
                            state_q <= StWaitP;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        p1_q    <= mul_cell_p1;
                        p2_q    <= mul_cell_p2;
                        p3_q    <= mul_cell_p3;
                        acc_q   <= 32'h0;
                        count_q <= 5'd0;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    acc_q   <= acc_d;
                    count_q <= count_d;
                    if (count_d == 5'd16) begin
                        state_q <= StFinal;
                    end
                end
                StFinal: begin
                    out_result <= hi_final;
                    out_valid  <= 1'b1;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_core_nios2_cpu_mul_combine.sv
// Bench: three combine stages (1, 2 and 4 bits per ITER cycle) share one stimulus stream and
// one modelled multiplier cell; each is checked cycle by cycle against a 64-bit product model.
module tb_nios_core_nios2_cpu_mul_combine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic        in_ready   [3];
    logic        busy       [3];
    logic        out_valid  [3];
    logic [31:0] out_result [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nios_core_nios2_cpu_mul_combine #(
            .ITER_PER_CYCLE(1 << g)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_ready   (in_ready[g]),
            .in_op      (in_op),
            .in_src1    (in_src1),
            .in_src2    (in_src2),
            .mul_cell_p1(p1),
            .mul_cell_p2(p2),
            .mul_cell_p3(p3),
            .out_valid  (out_valid[g]),
            .out_result (out_result[g]),
            .busy       (busy[g])
        );
    end

    // Upstream multiplier cell: products of this cycle's operands appear next cycle.
    always @(posedge clk) begin
        p1 <= {16'h0, in_src1[15:0]} * {16'h0, in_src2[15:0]};
        p2 <= {16'h0, in_src1[15:0]} * {16'h0, in_src2[31:16]};
        p3 <= {16'h0, in_src1[31:16]} * {16'h0, in_src2[15:0]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference result from a plain 64-bit product of (sign-extended) operands.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        logic [63:0] prod;
        ax = {32'h0, a};
        bx = {32'h0, b};
        if (op == 2'd2 || op == 2'd3) ax = {{32{a[31]}}, a};
        if (op == 2'd3) bx = {{32{b[31]}}, b};
        prod = ax * bx;
        return (op == 2'd0) ? prod[31:0] : prod[63:32];
    endfunction

    // Model state per DUT: cycle from which it accepts, expected strobes, held result.
    int          cyc = 0;
    bit          armed = 1'b0;
    int          ready_at [3] = '{0, 0, 0};
    logic [31:0] hold     [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] last_res [3];
    logic [31:0] q_val    [3][8];
    int          q_due    [3][8];
    int          q_head   [3] = '{0, 0, 0};
    int          q_tail   [3] = '{0, 0, 0};

    // Mid-cycle: check this cycle's outputs, then apply this cycle's inputs to the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (armed) begin
                bit exp_ready;
                bit exp_v;
                exp_ready = (cyc >= ready_at[d]);
                exp_v = (q_head[d] != q_tail[d]) && (q_due[d][q_head[d] % 8] == cyc);
                check_eq($sformatf("dut%0d in_ready c%0d", d, cyc), {31'b0, in_ready[d]},
                         {31'b0, exp_ready});
                check_eq($sformatf("dut%0d busy c%0d", d, cyc), {31'b0, busy[d]},
                         {31'b0, !exp_ready});
                check_eq($sformatf("dut%0d out_valid c%0d", d, cyc), {31'b0, out_valid[d]},
                         {31'b0, exp_v});
                if (exp_v) begin
                    hold[d] = q_val[d][q_head[d] % 8];
                    q_head[d]++;
                end
                check_eq($sformatf("dut%0d out_result c%0d", d, cyc), out_result[d], hold[d]);
                if (out_valid[d]) last_res[d] = out_result[d];
            end
            if (reset) begin
                ready_at[d] = cyc + 1;
                hold[d]     = 32'h0;
                q_head[d]   = 0;
                q_tail[d]   = 0;
            end else if (in_valid && cyc >= ready_at[d]) begin
                int lat;
                lat = (in_op == 2'd0) ? 2 : 3 + 16 / (1 << d);
                q_val[d][q_tail[d] % 8] = ref_result(in_op, in_src1, in_src2);
                q_due[d][q_tail[d] % 8] = cyc + lat;
                q_tail[d]++;
                if (in_op != 2'd0) ready_at[d] = cyc + lat;
            end
        end
        if (reset) armed = 1'b1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait until every DUT is ready and nothing is outstanding.
    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            step();
            done = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (q_head[d] != q_tail[d] || in_ready[d] !== 1'b1) done = 1'b0;
            end
        end
        check_eq("drain idle", {31'b0, done}, 32'd1);
    endtask

    task automatic known_answer(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        for (int d = 0; d < 3; d++) last_res[d] = 32'hDEADBEEF;
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        step();
        in_valid = 1'b0;
        in_src1  = $urandom;
        in_src2  = $urandom;
        drain(40);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s dut%0d", tag, d), last_res[d], exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 5)
            0:       return 32'hFFFFFFFF;
            1:       return 32'h80000000;
            2:       return $urandom & 32'h8000FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_src1  = 32'hFFFFFFFF;
        in_src2  = 32'hFFFFFFFF;
        repeat (3) step();
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        known_answer("mul", 2'd0, 32'h00010003, 32'h00020005, 32'h000B000F);
        known_answer("mulxuu ones", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        known_answer("mulxss ones", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        known_answer("mulxsu ones", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        known_answer("mulxss min", 2'd3, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
        known_answer("mulxuu mix", 2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E);

        // Four streaming MULs, a MULX, then a MUL held until the slowest DUT takes it.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_op    = 2'd0;
            in_src1  = $urandom;
            in_src2  = $urandom;
            step();
        end
        in_op   = 2'($urandom_range(1, 3));
        in_src1 = $urandom;
        in_src2 = $urandom;
        step();
        in_op   = 2'd0;
        in_src1 = $urandom;
        in_src2 = $urandom;
        for (int i = 0; i < 40; i++) begin
            bit take;
            take = (cyc >= ready_at[0]);
            step();
            if (take) break;
        end
        in_valid = 1'b0;
        drain(40);

        // Reset while the 1-bit DUT sits at ITER count 7.
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_src1  = $urandom;
        in_src2  = $urandom;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        known_answer("mul after reset", 2'd0, 32'h00000007, 32'h00000006, 32'h0000002A);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_op    = 2'($urandom % 4);
            in_src1  = pick_operand();
            in_src2  = pick_operand();
            reset    = (($urandom % 250) == 0);
            step();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
